lm_sm_sequencer: RTL and testbench

- Sits between fetch and the decode stage. Registers each fetched instruction into the IF/ID slot that drives decode's IR/PC inputs.
- Expands every LM (opcode 0110) and SM (opcode 0111) into one micro-op per set bit of IR[7:0], lowest set bit first. Decode's priority encoder therefore always selects the correct register.
- Stalls fetch while a multi-register sequence is in progress.
- Provides a per-micro-op memory offset so later stages can form the address as RA+offset.

---
 rtl/lm_sm_sequencer.sv | 121 ++++++++++++
 tb/tb_lm_sm_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer: IF/ID slot register that expands LM/SM instructions into
// one micro-op per set bit of the register list, lowest bit first, and stalls
// fetch while a multi-register sequence is in progress.
// Optional build macro: LMSM_PERF_CNT_EN adds the perf_seq_stalls counter port.
module lm_sm_sequencer #(
  parameter int DATA_W = 16,
  parameter int LIST_W = 8,
  parameter int OFF_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] if_ir,
  input  logic [DATA_W-1:0] if_pc,
  input  logic              if_valid,
  output logic              fetch_ready,
  input  logic              id_stall,
  input  logic              flush,
  output logic [DATA_W-1:0] id_ir,
  output logic [DATA_W-1:0] id_pc,
  output logic              id_valid,
  output logic [OFF_W-1:0]  id_off,
  output logic              id_last
`ifdef LMSM_PERF_CNT_EN
  ,
  output logic [15:0]       perf_seq_stalls
`endif
);

  // Slot state; id_valid/id_last are decoded straight from it.
  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_SINGLE = 2'd1,
    S_SEQ    = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  ir_nxt, pc_nxt;
  logic [OFF_W-1:0]   off_nxt;

  logic               is_lmsm;
  logic [LIST_W-1:0]  in_list, in_rest;
  logic [LIST_W-1:0]  cur_list, cur_rest, cur_rest_rest;
  logic [DATA_W-1:0]  lmsm_ir;

  assign id_valid    = (state != S_EMPTY);
  assign id_last     = (state != S_SEQ);
  assign fetch_ready = ~id_stall & ~flush & (~id_valid | id_last);

  // Opcodes 0110 (LM) and 0111 (SM) share the top three bits 011.
  assign is_lmsm  = (if_ir[DATA_W-1 -: 3] == 3'b011);
  assign in_list  = if_ir[LIST_W-1:0];
  // x & (x-1) clears the lowest set bit; zero result means at most one bit set.
  assign in_rest  = in_list & (in_list - LIST_W'(1));
  assign cur_list = id_ir[LIST_W-1:0];
  assign cur_rest = cur_list & (cur_list - LIST_W'(1));
  assign cur_rest_rest = cur_rest & (cur_rest - LIST_W'(1));
  // IR[8] is cleared so decode's priority encoder only sees the list bits.
  assign lmsm_ir  = {if_ir[DATA_W-1:LIST_W+1], 1'b0, in_list};

  // Next-state and slot contents: flush > stall > accept > advance.
  always_comb begin
    state_nxt = state;
    ir_nxt    = id_ir;
    pc_nxt    = id_pc;
    off_nxt   = id_off;
    if (flush) begin
      state_nxt = S_EMPTY;
      off_nxt   = '0;
    end else if (id_stall) begin
      state_nxt = state;
    end else if (fetch_ready) begin
      pc_nxt  = if_pc;
      off_nxt = '0;
      if (!if_valid) begin
        state_nxt = S_EMPTY;
      end else if (!is_lmsm) begin
        ir_nxt    = if_ir;
        state_nxt = S_SINGLE;
      end else if (in_list == '0) begin
        // Empty list: burns the slot for one cycle, nothing issued.
        state_nxt = S_EMPTY;
      end else begin
        ir_nxt    = lmsm_ir;
        state_nxt = (in_rest == '0) ? S_SINGLE : S_SEQ;
      end
    end else begin
      // Only reachable in S_SEQ: step to the next register of the list.
      ir_nxt[LIST_W-1:0] = cur_rest;
      off_nxt            = id_off + OFF_W'(1);
      state_nxt          = (cur_rest_rest == '0) ? S_SINGLE : S_SEQ;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_EMPTY;
      id_ir  <= '0;
      id_pc  <= '0;
      id_off <= '0;
    end else begin
      state  <= state_nxt;
      id_ir  <= ir_nxt;
      id_pc  <= pc_nxt;
      id_off <= off_nxt;
    end
  end

`ifdef LMSM_PERF_CNT_EN
  // Counts cycles where an advancing sequence holds fetch off; saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_seq_stalls <= '0;
    end else if (id_valid && !id_last && !id_stall && !flush &&
                 perf_seq_stalls != 16'hFFFF) begin
      perf_seq_stalls <= perf_seq_stalls + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed bench for lm_sm_sequencer; expected values are hand-derived.
module tb_lm_sm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] if_ir, if_pc;
  logic        if_valid, id_stall, flush;
  logic        fetch_ready;
  logic [15:0] id_ir, id_pc;
  logic        id_valid, id_last;
  logic [2:0]  id_off;
`ifdef LMSM_PERF_CNT_EN
  logic [15:0] perf_seq_stalls;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lm_sm_sequencer dut (
    .clk(clk), .reset(reset),
    .if_ir(if_ir), .if_pc(if_pc), .if_valid(if_valid),
    .fetch_ready(fetch_ready), .id_stall(id_stall), .flush(flush),
    .id_ir(id_ir), .id_pc(id_pc), .id_valid(id_valid),
    .id_off(id_off), .id_last(id_last)
`ifdef LMSM_PERF_CNT_EN
    , .perf_seq_stalls(perf_seq_stalls)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks the whole slot in one call.
  task automatic chk_slot(input string tag, input logic [15:0] ir, input logic [15:0] pc,
                          input logic v, input logic [2:0] off, input logic last);
    chk({tag, ".ir"}, 32'(id_ir), 32'(ir));
    chk({tag, ".pc"}, 32'(id_pc), 32'(pc));
    chk({tag, ".valid"}, 32'(id_valid), 32'(v));
    chk({tag, ".off"}, 32'(id_off), 32'(off));
    chk({tag, ".last"}, 32'(id_last), 32'(last));
  endtask

  task automatic chk_perf(input string tag, input logic [15:0] exp);
`ifdef LMSM_PERF_CNT_EN
    chk(tag, 32'(perf_seq_stalls), 32'(exp));
`endif
  endtask

  // Advance one clock; outputs settle 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] lst;
    reset = 1'b1; if_ir = '0; if_pc = '0; if_valid = 1'b0; id_stall = 1'b0; flush = 1'b0;
    tick(); tick();
    chk_slot("rst", 16'h0000, 16'h0000, 1'b0, 3'd0, 1'b1);
    chk("rst.fr", 32'(fetch_ready), 32'd1);
    chk_perf("rst.perf", 16'd0);

    // Plain ADD
    reset = 1'b0; if_ir = 16'h0298; if_pc = 16'h0010; if_valid = 1'b1; #1;
    chk("add.fr0", 32'(fetch_ready), 32'd1);
    tick();
    chk_slot("add", 16'h0298, 16'h0010, 1'b1, 3'd0, 1'b1);
    chk("add.fr1", 32'(fetch_ready), 32'd1);

    // LM 0x6A85: three micro-ops, next instruction held until the fourth cycle
    if_ir = 16'h6A85; if_pc = 16'h0020; tick();
    if_ir = 16'h1234; if_pc = 16'h0030;
    chk_slot("lm0", 16'h6A85, 16'h0020, 1'b1, 3'd0, 1'b0);
    chk("lm0.fr", 32'(fetch_ready), 32'd0);
    tick();
    chk_slot("lm1", 16'h6A84, 16'h0020, 1'b1, 3'd1, 1'b0);
    chk("lm1.fr", 32'(fetch_ready), 32'd0);
    tick();
    chk_slot("lm2", 16'h6A80, 16'h0020, 1'b1, 3'd2, 1'b1);
    chk("lm2.fr", 32'(fetch_ready), 32'd1);
    tick();
    chk_slot("lm_next", 16'h1234, 16'h0030, 1'b1, 3'd0, 1'b1);
    chk_perf("lm.perf", 16'd2);

    // SM with IR[8]=1 and a single bit; then SM with empty list
    if_ir = 16'h7F01; if_pc = 16'h0040; tick();
    chk_slot("sm1", 16'h7E01, 16'h0040, 1'b1, 3'd0, 1'b1);
    if_ir = 16'h7E00; if_pc = 16'h0050; tick();
    chk("sm0.valid", 32'(id_valid), 32'd0);
    chk("sm0.last", 32'(id_last), 32'd1);
    chk("sm0.fr", 32'(fetch_ready), 32'd1);

    // LM 0x6A0F with a 3-cycle stall at id_off=1
    if_ir = 16'h6A0F; if_pc = 16'h0060; tick();
    if_ir = 16'h2222; if_pc = 16'h0062;
    chk_slot("st0", 16'h6A0F, 16'h0060, 1'b1, 3'd0, 1'b0);
    tick();
    chk_slot("st1", 16'h6A0E, 16'h0060, 1'b1, 3'd1, 1'b0);
    id_stall = 1'b1; #1;
    chk("st.fr", 32'(fetch_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_slot("st_hold", 16'h6A0E, 16'h0060, 1'b1, 3'd1, 1'b0);
    end
    id_stall = 1'b0; tick();
    chk_slot("st2", 16'h6A0C, 16'h0060, 1'b1, 3'd2, 1'b0);
    tick();
    chk_slot("st3", 16'h6A08, 16'h0060, 1'b1, 3'd3, 1'b1);
    tick();
    chk_slot("st_next", 16'h2222, 16'h0062, 1'b1, 3'd0, 1'b1);
    chk_perf("st.perf", 16'd5);

    // LM 0x6AFF flushed at id_off=2
    if_ir = 16'h6AFF; if_pc = 16'h0070; tick();
    tick(); tick();
    chk_slot("fl2", 16'h6AFC, 16'h0070, 1'b1, 3'd2, 1'b0);
    flush = 1'b1; if_ir = 16'h3333; if_pc = 16'h0080; #1;
    chk("fl.fr_in", 32'(fetch_ready), 32'd0);
    tick();
    flush = 1'b0; if_valid = 1'b0; #1;
    chk("fl.valid", 32'(id_valid), 32'd0);
    chk("fl.last", 32'(id_last), 32'd1);
    chk("fl.off", 32'(id_off), 32'd0);
    chk("fl.fr", 32'(fetch_ready), 32'd1);
    chk("fl.dropped", 32'(id_ir == 16'h3333), 32'd0);
    chk_perf("fl.perf", 16'd7);
    tick();
    chk("idle.valid", 32'(id_valid), 32'd0);

    // Full 8-bit list: offsets 0..7, last only on the eighth
    if_ir = 16'h60FF; if_pc = 16'h0090; if_valid = 1'b1; tick();
    if_valid = 1'b0;
    lst = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      chk_slot("full", {8'h60, lst}, 16'h0090, 1'b1, 3'(i), (i == 7));
      lst = lst & (lst - 8'd1);
      tick();
    end
    chk("full.after", 32'(id_valid), 32'd0);

    // Reset in the middle of a sequence (id_off=3)
    if_ir = 16'h6AFF; if_pc = 16'h00A0; if_valid = 1'b1; tick();
    tick(); tick(); tick();
    chk_slot("rs3", 16'h6AF8, 16'h00A0, 1'b1, 3'd3, 1'b0);
    reset = 1'b1; tick();
    chk_slot("rs", 16'h0000, 16'h0000, 1'b0, 3'd0, 1'b1);
    chk("rs.fr", 32'(fetch_ready), 32'd1);
    chk_perf("rs.perf", 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
